stopwatch_lap: RTL
==================

# stopwatch_lap

Parametrised MM:SS stopwatch core with on-chip button conditioning, lap freeze, clear, and selectable wrap or saturate at 59:59. It sits between the raw board buttons and the `sevenseg` multiplexer. It presents four packed BCD digits that `sevenseg` consumes directly, and it supersedes the single-button stopwatch with a correct same-cycle BCD carry chain.

## Interface
- `TICKS_PER_SEC`, default 100: clk cycles per counted second; legal range ≥2.
- `WRAP`, default 1: 1 = roll 59:59→00:00; 0 = saturate at 59:59 and stop.
- `DEB_CYCLES`, default 16: stable-sample count for the debouncer; used only with `STOPWATCH_DEBOUNCE_EN`.
- `clk` in, 1: single clock. All state is updated on its rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `btn_ss` in, 1: start/stop button, raw and asynchronous.
- `btn_lap` in, 1: lap/clear button, raw and asynchronous.
- `disp` out, 16: {min1, min0, sec1, sec0} in BCD; feeds `sevenseg` digit0..digit3.
- `running` out, 1: the count is advancing.
- `lap_active` out, 1: `disp` shows the frozen lap value.
- `tick` out, 1: one-cycle pulse on every counted second.
- `ovf` out, 1: 59:59 rollover indication.

## Operation
- **Reset.** On `rst` all of the following are 0, so `disp` reads 00:00:
  - prescaler, live digits, lap register
  - `running`, `lap_active`, `tick`, `ovf`
  - synchroniser and edge registers
- **Button conditioning.** Each button passes through a 2-FF synchroniser, then a rising-edge detector. The result is a one-cycle internal pulse, `ss_p` or `lap_p`.
- **Start/stop.** `ss_p` toggles `running`.
- **Lap button, decided by `running` and `lap_active` before this cycle's `ss_p` is applied:**
  - Running: toggle `lap_active`. When setting it, capture the live digits into the lap register on the same edge.
  - Stopped with `lap_active`=1: clear `lap_active`.
  - Stopped with `lap_active`=0: clear. The prescaler and live digits go to 0, and `ovf` goes to 0.
- **Prescaler.**
  - Counts 0..TICKS_PER_SEC-1 only while `running`=1.
  - When stopped it holds its value, so resuming keeps the fractional second.
  - At terminal count with `running`=1 it reloads to 0, asserts `tick`, and increments the seconds.
- **Carry chain.** Every digit resolves on the same edge as `tick`, with no intermediate out-of-range value ever registered:
  - sec0 0–9, carries into sec1 0–5
  - sec1 carries into min0 0–9
  - min0 carries into min1 0–5
- **59:59 + tick with WRAP=1.** Digits go to 00:00, `ovf` pulses for one cycle, and `running` stays 1.
- **59:59 + tick with WRAP=0.** Digits hold at 59:59, `running` goes to 0, and `ovf` sets sticky until the next clear or `rst`.
- **`disp` source.** `disp` = `lap_active` ? lap register : live digits. This is a combinational mux of registers.
- **Lap while counting.** The live digits keep counting while `lap_active`=1.

## Timing
- **Button latency without debounce.** Let edge k be the first clk edge that samples the button high. `running` or `lap_active` changes at edge k+2 (FF1 at k, FF2 at k+1, pulse-qualified update at k+2).
- **Button hold.** A button held high produces exactly one pulse. A second action requires a low level seen by the synchroniser for at least one sample.
- **Tick period.** `tick` is high exactly one cycle in every TICKS_PER_SEC running cycles. The digit update and `tick` share the same edge.
- **Clear.** Clear takes effect at edge k+2. Clear wins over a coincident terminal count: no tick, digits are 00:00.
- **`ss_p` coinciding with terminal count.** The tick is still counted, because `running` was 1 in that cycle.
- **`rst` mid-operation.** `rst` forces all outputs to their reset values immediately, independent of `clk`. A pulse in flight is discarded.
- **Both buttons in one cycle.** Both take effect on the same edge. The lap action follows the pre-toggle rules above.

## Configuration
- **`STOPWATCH_DEBOUNCE_EN` defined.**
  - A per-button counter follows each synchroniser.
  - The conditioned level changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles.
  - The edge detector acts on the conditioned level.
  - Button latency becomes k+2+DEB_CYCLES. A glitch shorter than DEB_CYCLES cycles has no effect.
- **Not defined.** The debouncer is absent, `DEB_CYCLES` is ignored, and latency is k+2.

## Test plan
1. **Start and count.** TICKS_PER_SEC=4, debounce off: `rst`, then pulse `btn_ss`. The response must be:
   - `running`=1 at edge k+2
   - `tick` every 4 cycles
   - `disp`=16'h0010 after 10 ticks
2. **Carry and wrap.** Run 3599 ticks → `disp`=16'h5959. The next tick gives:
   - with WRAP=1: 16'h0000, one-cycle `ovf`, `running`=1
   - with WRAP=0: 16'h5959 held, `running`=0, `ovf` held high
3. **Lap freeze.** At `disp`=16'h0012 press lap → `lap_active`=1 and `disp` frozen at 16'h0012. Five ticks later press lap → `disp`=16'h0017.
4. **Stop, resume, clear.** Stop two cycles into a second, resume, and the next `tick` comes 2 cycles later. While stopped, lap with `lap_active`=0 → `disp`=16'h0000 and prescaler 0.
5. **Coincident events.**
   - `btn_ss` and `btn_lap` pulsed together while running → `running`=0 and `lap_active`=1 on the same edge.
   - Clear coinciding with terminal count → no `tick`, `disp`=16'h0000.
6. **Async reset and debounce.** Assert `rst` mid-count between edges → outputs are 0 before the next edge. With `STOPWATCH_DEBOUNCE_EN`, DEB_CYCLES=8:
   - a 5-cycle `btn_ss` glitch → no change
   - a 12-cycle press → toggle at k+10

Source files
------------

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: MM:SS stopwatch with button conditioning, lap freeze, clear,
// and wrap or saturate at 59:59. Optional debouncer: STOPWATCH_DEBOUNCE_EN.
// Params: TICKS_PER_SEC (clk cycles per second), WRAP (1 roll, 0 saturate),
//         DEB_CYCLES (debounce stable count, debounce build only).
// Ports: clk, rst (async, active high), btn_ss/btn_lap (raw buttons),
//        disp {min1,min0,sec1,sec0} BCD, running, lap_active, tick, ovf.
module stopwatch_lap #(
    parameter int TICKS_PER_SEC = 100,
    parameter int WRAP          = 1,
    parameter int DEB_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lap,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        tick,
    output logic        ovf
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PTERM = PW'(TICKS_PER_SEC - 1);

    logic [1:0]    ss_sync;
    logic [1:0]    lap_sync;
    logic          ss_lvl;
    logic          lap_lvl;
    logic          ss_q;
    logic          lap_q;
    logic          ss_p;
    logic          lap_p;
    logic [PW-1:0] presc;
    logic [15:0]   live;
    logic [15:0]   lap_reg;
    logic [15:0]   live_inc;
    logic          at_max;
    logic          term;
    logic          clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync  <= 2'b00;
            lap_sync <= 2'b00;
        end else begin
            ss_sync  <= {ss_sync[0], btn_ss};
            lap_sync <= {lap_sync[0], btn_lap};
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);

    logic          ss_deb;
    logic          lap_deb;
    logic [DW-1:0] ss_cnt;
    logic [DW-1:0] lap_cnt;

    // Conditioned level follows the synchronised input only after it has
    // disagreed for DEB_CYCLES consecutive samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_deb  <= 1'b0;
            lap_deb <= 1'b0;
            ss_cnt  <= '0;
            lap_cnt <= '0;
        end else begin
            if (ss_sync[1] != ss_deb) begin
                if (ss_cnt == DLAST) begin
                    ss_deb <= ss_sync[1];
                    ss_cnt <= '0;
                end else begin
                    ss_cnt <= ss_cnt + DW'(1);
                end
            end else begin
                ss_cnt <= '0;
            end
            if (lap_sync[1] != lap_deb) begin
                if (lap_cnt == DLAST) begin
                    lap_deb <= lap_sync[1];
                    lap_cnt <= '0;
                end else begin
                    lap_cnt <= lap_cnt + DW'(1);
                end
            end else begin
                lap_cnt <= '0;
            end
        end
    end

    assign ss_lvl  = ss_deb;
    assign lap_lvl = lap_deb;
`else
    assign ss_lvl  = ss_sync[1];
    assign lap_lvl = lap_sync[1];
`endif

    assign ss_p  = ss_lvl & ~ss_q;
    assign lap_p = lap_lvl & ~lap_q;
    assign term  = running && (presc == PTERM);
    // Lap decision uses the pre-toggle running/lap_active state.
    assign clear = lap_p && !running && !lap_active;

    // Whole carry chain resolved combinationally; 59:59 yields 00:00.
    always_comb begin
        live_inc = live;
        at_max   = (live == 16'h5959);
        if (live[3:0] != 4'd9) begin
            live_inc[3:0] = live[3:0] + 4'd1;
        end else begin
            live_inc[3:0] = 4'd0;
            if (live[7:4] != 4'd5) begin
                live_inc[7:4] = live[7:4] + 4'd1;
            end else begin
                live_inc[7:4] = 4'd0;
                if (live[11:8] != 4'd9) begin
                    live_inc[11:8] = live[11:8] + 4'd1;
                end else begin
                    live_inc[11:8] = 4'd0;
                    if (live[15:12] != 4'd5) begin
                        live_inc[15:12] = live[15:12] + 4'd1;
                    end else begin
                        live_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q       <= 1'b0;
            lap_q      <= 1'b0;
            presc      <= '0;
            live       <= 16'h0000;
            lap_reg    <= 16'h0000;
            running    <= 1'b0;
            lap_active <= 1'b0;
            tick       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            ss_q    <= ss_lvl;
            lap_q   <= lap_lvl;
            tick    <= 1'b0;
            running <= running ^ ss_p;
            if (WRAP != 0) begin
                ovf <= 1'b0;
            end
            if (lap_p) begin
                if (running) begin
                    lap_active <= ~lap_active;
                    if (!lap_active) begin
                        lap_reg <= live;
                    end
                end else begin
                    lap_active <= 1'b0;
                end
            end
            if (clear) begin
                presc <= '0;
                live  <= 16'h0000;
                ovf   <= 1'b0;
            end else if (term) begin
                presc <= '0;
                tick  <= 1'b1;
                if (at_max && (WRAP == 0)) begin
                    // Saturate: hold 59:59, stop, sticky overflow.
                    running <= 1'b0;
                    ovf     <= 1'b1;
                end else begin
                    live <= live_inc;
                    if (at_max) begin
                        ovf <= 1'b1;
                    end
                end
            end else if (running) begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign disp = lap_active ? lap_reg : live;

endmodule
